// File: rtl/ccr_unit.sv
// ccr_unit: condition-code register for a simple pipelined core.
//
// Keeps the architectural flags {V,C,N,Z}. They are loaded from the ALU on
// flag-writing functions and set/cleared by SETC/CLRC. A taken conditional
// jump clears the flag it tested. The flags are saved to a shadow register on
// interrupt entry and restored on return from interrupt (one level, no
// nesting).
//
// Ports
//   clk        in   clock; all state changes on the rising edge
//   rst_n      in   synchronous active-low reset
//   ex_valid   in   execute stage holds a valid instruction
//   alu_func   in   ALU function code of the execute-stage instruction
//   alu_flags  in   ALU outFlags: bit0 Z, bit1 N, bit2 C, bit3 V (15:4 ignored)
//   stall      in   pipeline frozen: blocks ALU, SETC/CLRC and jump-clear paths
//   setc/clrc  in   set / clear C (clrc wins if both are high)
//   jmp_cond   in   00 always, 01 JZ, 10 JN, 11 JC
//   jmp_eval   in   a jump is resolved this cycle
//   int_req    in   interrupt entry pulse
//   rti        in   return-from-interrupt pulse
//   flags_out  out  current CCR {V,C,N,Z}
//   jmp_taken  out  combinational jump outcome from the registered CCR
//   int_ack    out  one-cycle registered pulse when the flags are saved
//   in_isr     out  high while the shadow holds saved flags
module ccr_unit #(
  // Must be between 4 and 15: bits 0..3 are Z, N, C, V.
  parameter int unsigned FLAG_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ex_valid,
  input  logic [3:0]        alu_func,
  input  logic [15:0]       alu_flags,
  input  logic              stall,
  input  logic              setc,
  input  logic              clrc,
  input  logic [1:0]        jmp_cond,
  input  logic              jmp_eval,
  input  logic              int_req,
  input  logic              rti,
  output logic [FLAG_W-1:0] flags_out,
  output logic              jmp_taken,
  output logic              int_ack,
  output logic              in_isr
);

  localparam int unsigned BitZ = 0;
  localparam int unsigned BitN = 1;
  localparam int unsigned BitC = 2;

  typedef enum logic [0:0] {StIdle, StSaved} state_e;

  state_e            state_q;
  logic [FLAG_W-1:0] ccr_q, ccr_d;
  logic [FLAG_W-1:0] shadow_q;
  logic              int_ack_q;
  logic              is_flag_wr;
  logic              cond_flag;

  // Upper ALU flag bits are architecturally meaningless here.
  logic unused_alu_flags;
  assign unused_alu_flags = ^alu_flags[15:FLAG_W];

  always_comb begin
    is_flag_wr = 1'b0;
    case (alu_func)
      4'b1000, 4'b1001, 4'b1010, 4'b1011,
      4'b1100, 4'b1101, 4'b0110, 4'b0111: is_flag_wr = 1'b1;
      default:                            is_flag_wr = 1'b0;
    endcase
  end

  // Jumps see only the registered CCR; there is no forwarding from the ALU.
  always_comb begin
    cond_flag = 1'b1;
    case (jmp_cond)
      2'b00:   cond_flag = 1'b1;
      2'b01:   cond_flag = ccr_q[BitZ];
      2'b10:   cond_flag = ccr_q[BitN];
      default: cond_flag = ccr_q[BitC];
    endcase
  end

  assign jmp_taken = jmp_eval & cond_flag;

  // Sources are applied lowest priority first so each higher-priority source
  // overwrites only the bits it owns.
  always_comb begin
    ccr_d = ccr_q;
    if (!stall && jmp_taken) begin
      case (jmp_cond)
        2'b01:   ccr_d[BitZ] = 1'b0;
        2'b10:   ccr_d[BitN] = 1'b0;
        2'b11:   ccr_d[BitC] = 1'b0;
        default: ;
      endcase
    end
    if (!stall && (setc || clrc)) begin
      ccr_d[BitC] = ~clrc;
    end
    if (!stall && ex_valid && is_flag_wr) begin
      ccr_d = alu_flags[FLAG_W-1:0];
    end
    if (state_q == StSaved && rti) begin
      ccr_d = shadow_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      ccr_q     <= '0;
      shadow_q  <= '0;
      int_ack_q <= 1'b0;
    end else begin
      ccr_q     <= ccr_d;
      int_ack_q <= 1'b0;
      case (state_q)
        StIdle: begin
          // Save the pre-update CCR; a same-cycle ALU write still reaches ccr_q.
          if (int_req) begin
            shadow_q  <= ccr_q;
            int_ack_q <= 1'b1;
            state_q   <= StSaved;
          end
        end
        default: begin
          if (rti) begin
            state_q <= StIdle;
          end
        end
      endcase
    end
  end

  assign flags_out = ccr_q;
  assign int_ack   = int_ack_q;
  assign in_isr    = (state_q == StSaved);

endmodule

// File: tb/tb_ccr_unit.sv
module tb_ccr_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ex_valid;
  logic [3:0]  alu_func;
  logic [15:0] alu_flags;
  logic        stall;
  logic        setc;
  logic        clrc;
  logic [1:0]  jmp_cond;
  logic        jmp_eval;
  logic        int_req;
  logic        rti;
  logic [3:0]  flags_out;
  logic        jmp_taken;
  logic        int_ack;
  logic        in_isr;

  ccr_unit #(.FLAG_W(4)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ex_valid  (ex_valid),
    .alu_func  (alu_func),
    .alu_flags (alu_flags),
    .stall     (stall),
    .setc      (setc),
    .clrc      (clrc),
    .jmp_cond  (jmp_cond),
    .jmp_eval  (jmp_eval),
    .int_req   (int_req),
    .rti       (rti),
    .flags_out (flags_out),
    .jmp_taken (jmp_taken),
    .int_ack   (int_ack),
    .in_isr    (in_isr)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] flags;
    logic       ack;
    logic       isr;
  } exp_t;

  exp_t exp_q[$];

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state.
  logic [3:0] m_ccr    = 4'b0;
  logic [3:0] m_shadow = 4'b0;
  logic       m_saved  = 1'b0;
  logic       m_ack    = 1'b0;

  task automatic check_val(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic model_jt();
    logic f;
    if (jmp_cond == 2'b00) f = 1'b1;
    else                   f = m_ccr[jmp_cond - 1];
    return jmp_eval & f;
  endfunction

  // One clock: check the combinational jump outcome, predict the next state,
  // queue it, then pop and compare after the edge.
  task automatic tick();
    logic       jt;
    logic       alu_w;
    logic       restore;
    logic       save;
    logic [3:0] nxt;
    exp_t       e;
    exp_t       got;
    #1;
    jt = model_jt();
    check_val("jmp_taken", {15'b0, jmp_taken}, {15'b0, jt});
    if (!rst_n) begin
      m_ccr = 4'b0; m_shadow = 4'b0; m_saved = 1'b0; m_ack = 1'b0;
    end else begin
      alu_w   = !stall && ex_valid &&
                (alu_func inside {4'b1000, 4'b1001, 4'b1010, 4'b1011,
                                  4'b1100, 4'b1101, 4'b0110, 4'b0111});
      restore = m_saved && rti;
      save    = !m_saved && int_req;
      for (int b = 0; b < 4; b++) begin
        if (restore)                                     nxt[b] = m_shadow[b];
        else if (alu_w)                                  nxt[b] = alu_flags[b];
        else if (b == 2 && !stall && (setc || clrc))     nxt[b] = !clrc;
        else if (!stall && jt && jmp_cond != 2'b00 && (int'(jmp_cond) - 1 == b)) nxt[b] = 1'b0;
        else                                             nxt[b] = m_ccr[b];
      end
      if (save) m_shadow = m_ccr;
      m_ack   = save;
      m_saved = m_saved ? !rti : int_req;
      m_ccr   = nxt;
    end
    e.flags = m_ccr; e.ack = m_ack; e.isr = m_saved;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    got.flags = flags_out; got.ack = int_ack; got.isr = in_isr;
    check_val("flags_out", {12'b0, got.flags}, {12'b0, e.flags});
    check_val("int_ack",   {15'b0, got.ack},   {15'b0, e.ack});
    check_val("in_isr",    {15'b0, got.isr},   {15'b0, e.isr});
  endtask

  task automatic quiet();
    rst_n = 1'b1; ex_valid = 1'b0; alu_func = 4'b0000; alu_flags = 16'h0;
    stall = 1'b0; setc = 1'b0; clrc = 1'b0; jmp_cond = 2'b00; jmp_eval = 1'b0;
    int_req = 1'b0; rti = 1'b0;
  endtask

  task automatic alu(input logic [3:0] func, input logic [15:0] fl);
    ex_valid = 1'b1; alu_func = func; alu_flags = fl;
  endtask

  initial begin
    quiet();
    rst_n = 1'b0;
    tick();
    check_val("reset_flags", {12'b0, flags_out}, 16'h0);
    check_val("reset_isr", {15'b0, in_isr}, 16'h0);
    quiet(); tick();

    // ALU write, then non-writer leaves flags alone.
    alu(4'b1000, 16'h0001); tick();
    check_val("add_flags", {12'b0, flags_out}, 16'h1);
    quiet(); alu(4'b0011, 16'h0006); tick();
    check_val("mov1_keep", {12'b0, flags_out}, 16'h1);
    quiet(); alu(4'b0101, 16'h000E); tick();

    // JZ taken clears Z; repeat is not taken.
    quiet(); jmp_eval = 1'b1; jmp_cond = 2'b01; #1;
    check_val("jz_taken", {15'b0, jmp_taken}, 16'h1);
    tick();
    check_val("jz_clear", {12'b0, flags_out}, 16'h0);
    #1;
    check_val("jz_not_taken", {15'b0, jmp_taken}, 16'h0);
    tick();
    jmp_cond = 2'b00; tick();

    // Interrupt save / update / restore.
    quiet(); setc = 1'b1; tick();
    check_val("setc", {12'b0, flags_out}, 16'h4);
    quiet(); int_req = 1'b1; tick();
    check_val("int_ack_pulse", {15'b0, int_ack}, 16'h1);
    check_val("in_isr_set", {15'b0, in_isr}, 16'h1);
    quiet(); alu(4'b1001, 16'h0003); tick();
    check_val("isr_sub", {12'b0, flags_out}, 16'h3);
    check_val("int_ack_drop", {15'b0, int_ack}, 16'h0);
    quiet(); rti = 1'b1; tick();
    check_val("rti_restore", {12'b0, flags_out}, 16'h4);
    check_val("rti_isr", {15'b0, in_isr}, 16'h0);

    // No nesting; rti in IDLE ignored.
    quiet(); int_req = 1'b1; tick();
    quiet(); alu(4'b1000, 16'h0001); tick();
    quiet(); int_req = 1'b1; tick();
    check_val("nested_no_ack", {15'b0, int_ack}, 16'h0);
    quiet(); rti = 1'b1; int_req = 1'b1; tick();
    check_val("shadow_kept", {12'b0, flags_out}, 16'h4);
    quiet(); rti = 1'b1; tick();
    check_val("rti_idle", {12'b0, flags_out}, 16'h4);

    // Stall blocks ALU and SETC; then ALU beats SETC/CLRC.
    quiet(); stall = 1'b1; alu(4'b0110, 16'h000A); setc = 1'b1; tick();
    check_val("stall_hold", {12'b0, flags_out}, 16'h4);
    stall = 1'b0; clrc = 1'b1; tick();
    check_val("alu_over_setc", {12'b0, flags_out}, 16'hA);
    // SETC with taken JN; ALU with taken JC.
    quiet(); setc = 1'b1; jmp_eval = 1'b1; jmp_cond = 2'b10; tick();
    check_val("setc_jn", {12'b0, flags_out}, 16'hC);
    quiet(); alu(4'b1000, 16'h0004); jmp_eval = 1'b1; jmp_cond = 2'b11; tick();
    check_val("alu_over_jc", {12'b0, flags_out}, 16'h4);
    // Stall does not block interrupt entry.
    quiet(); stall = 1'b1; int_req = 1'b1; tick();
    check_val("stall_int_ack", {15'b0, int_ack}, 16'h1);

    // Reset mid-ISR.
    quiet(); alu(4'b1010, 16'h000F); tick();
    check_val("isr_all_ones", {12'b0, flags_out}, 16'hF);
    quiet(); rst_n = 1'b0; rti = 1'b1; setc = 1'b1; alu(4'b1000, 16'h0007); tick();
    check_val("rst_flags", {12'b0, flags_out}, 16'h0);
    check_val("rst_isr", {15'b0, in_isr}, 16'h0);
    quiet(); rti = 1'b1; tick();
    check_val("rti_after_rst", {12'b0, flags_out}, 16'h0);

    // Randomised traffic against the model.
    for (int i = 0; i < 300; i++) begin
      rst_n     = ($urandom_range(0, 49) != 0);
      ex_valid  = $urandom_range(0, 1);
      alu_func  = 4'($urandom_range(0, 15));
      alu_flags = 16'($urandom);
      stall     = ($urandom_range(0, 3) == 0);
      setc      = ($urandom_range(0, 3) == 0);
      clrc      = ($urandom_range(0, 3) == 0);
      jmp_cond  = 2'($urandom_range(0, 3));
      jmp_eval  = $urandom_range(0, 1);
      int_req   = ($urandom_range(0, 7) == 0);
      rti       = ($urandom_range(0, 7) == 0);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ccr_unit.md
CCR_UNIT -- requirements
Module: ccr_unit

Interface
REQ-001 SHALL have parameter FLAG_W, default 4, meaning the number of architectural flags kept (Z,N,C,V).
REQ-002 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset; synchronous, active-low.
REQ-004 SHALL have port ex_valid  input  1  the execute stage holds a valid instruction this cycle.
REQ-005 SHALL have port alu_func  input  4  the ALU function code of the execute-stage instruction.
REQ-006 SHALL have port alu_flags  input  16  the ALU outFlags: bit0 Z, bit1 N, bit2 C, bit3 V; bits 15:4 are ignored.
REQ-007 SHALL have port stall  input  1  the pipeline is frozen; no flag update, jump clear or SETC/CLRC.
REQ-008 SHALL have port setc / clrc  input  1 each  set or clear the C flag.
REQ-009 SHALL have port jmp_cond  input  2  the jump condition: 00 unconditional, 01 JZ, 10 JN, 11 JC.
REQ-010 SHALL have port jmp_eval  input  1  a jump instruction is being resolved this cycle.
REQ-011 SHALL have port int_req  input  1  an interrupt entry pulse.
REQ-012 SHALL have port rti  input  1  a return-from-interrupt pulse.
REQ-013 SHALL have port flags_out  output  FLAG_W  the current CCR value {V,C,N,Z}.
REQ-014 SHALL have port jmp_taken  output  1  combinational: the jump resolves taken.
REQ-015 SHALL have port int_ack  output  1  a one-cycle registered pulse when the flags are saved.
REQ-016 SHALL have port in_isr  output  1  high while the state is SAVED.

Function
REQ-017 SHALL classify the flag-writing functions as: 1000 ADD, 1001 SUB, 1010 AND, 1011 OR, 1100 SHL, 1101 SHR, 0110 INC, 0111 DEC.
REQ-018 SHALL leave the flags unchanged for every other code (0000 NOP, 0011 MOV1, 0100 MOV2, 0101 NOT, and the rest).
REQ-019 SHALL load alu_flags[3:0] into the CCR one cycle after an edge where ex_valid=1, stall=0 and alu_func is a flag-writer.
REQ-020 SHALL compute jmp_taken = jmp_eval & (cond 00, or Z for 01, or N for 10, or C for 11), using the registered CCR only, with no ALU forwarding.
REQ-021 SHALL clear, on a taken conditional jump (01/10/11) with stall=0, the tested flag at the next edge; an unconditional jump clears nothing.
REQ-022 SHALL apply setc (C<=1) or clrc (C<=0) when stall=0; if both are high, clrc wins.
REQ-023 SHALL resolve same-cycle updates by priority: rst_n > rti restore > int save > ALU write > SETC/CLRC > jump clear.
REQ-024 SHALL let a lower-priority source modify only bits not written by a higher one (e.g. an ALU write plus a taken JZ gives Z from the ALU).
REQ-025 SHALL implement the FSM states IDLE and SAVED.
REQ-026 SHALL, on int_req=1 in IDLE, copy the CCR into the shadow register, pulse int_ack, and go to SAVED; any same-cycle ALU update still lands in the CCR.
REQ-027 SHALL, in SAVED, raise in_isr and keep updating the CCR normally.
REQ-028 SHALL ignore int_req while in SAVED (no nesting): no shadow overwrite and no int_ack.
REQ-029 SHALL, on rti=1 in SAVED, restore the CCR from the shadow at the next edge, overriding all other sources, and go to IDLE.
REQ-030 SHALL ignore rti while in IDLE.
REQ-031 SHALL treat int_req and rti high together in SAVED as rti.
REQ-032 SHALL treat int_req and rti high together in IDLE as int_req.
REQ-033 SHALL let stall block only the ALU, SETC/CLRC and jump-clear paths; int_req and rti act regardless of stall.

Reset
REQ-034 SHALL, on rst_n=0 at a rising edge, set CCR=0, shadow=0, state=IDLE, int_ack=0; in_isr and jmp_taken follow from this.
REQ-035 SHALL make reset abort SAVED mid-interrupt, discarding the shadow.
REQ-036 SHALL ignore all other inputs during the reset cycle.

Verification
REQ-037 SHALL cover: ADD with alu_flags=16'h0001, ex_valid=1 -> flags_out=4'b0001 next cycle; then MOV1 with alu_flags=16'h0006 -> flags_out stays 4'b0001.
REQ-038 SHALL cover: CCR=4'b0001, jmp_eval=1, jmp_cond=01 -> jmp_taken=1 same cycle, flags_out=4'b0000 next cycle; repeat -> jmp_taken=0.
REQ-039 SHALL cover: CCR=4'b0100, int_req pulse -> int_ack=1 one cycle, in_isr=1; SUB writing 4'b0011 -> CCR=4'b0011; rti -> CCR=4'b0100, in_isr=0.
REQ-040 SHALL cover: in SAVED, second int_req -> no int_ack and shadow unchanged; rti in IDLE -> CCR unchanged.
REQ-041 SHALL cover: stall=1 with a valid INC writing 4'b1010, setc=1 -> CCR unchanged; same stimulus with stall=0, setc=1, clrc=1 -> CCR=4'b1010 (ALU write wins).
REQ-042 SHALL cover: rst_n=0 while in SAVED with CCR=4'b1111 -> next cycle CCR=0, in_isr=0; a following rti is ignored.
